// File: rtl/mas_div_pkg.sv
// -----------------------------------------------------------------------------
// mas_div_pkg
// Shared definitions for the sequential restoring divider (mas_div_seq).
//   STATE_W : width of the divider FSM state encoding
//   state_t : FSM states
//             IDLE - waiting for an operand pair
//             RUN  - producing one quotient bit per cycle
//             DONE - result presented until the consumer takes it
// No ports (package only).
// -----------------------------------------------------------------------------
package mas_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mas_div_step.sv
// -----------------------------------------------------------------------------
// mas_div_step
// One combinational iteration of radix-2 restoring division: shift the next
// dividend bit into the partial remainder, compare against the divisor and
// subtract when it fits. Kept separate so an unrolled divider can chain copies.
// Ports:
//   r_in    [WIDTH-1:0] partial remainder entering the step (always < divisor)
//   q_msb               dividend/quotient bit shifted into the remainder
//   divisor [WIDTH-1:0] divisor (non-zero when used)
//   r_out   [WIDTH-1:0] partial remainder leaving the step
//   q_bit               quotient bit produced by this step
// -----------------------------------------------------------------------------
module mas_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The trial value needs WIDTH+1 bits for the compare, but whenever the
  // subtraction happens the true difference is below the divisor, so the
  // WIDTH-bit modular difference is exact and the top bit can be dropped.
  always_comb begin
    trial = {r_in, q_msb};
    if (trial >= {1'b0, divisor}) begin
      r_out = trial[WIDTH-1:0] - divisor;
      q_bit = 1'b1;
    end else begin
      r_out = trial[WIDTH-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/mas_div_seq.sv
// -----------------------------------------------------------------------------
// mas_div_seq
// Sequential unsigned radix-2 restoring divider. Accepts an operand pair over
// a valid/ready handshake, runs WIDTH iterations (one quotient bit per cycle)
// and holds quotient/remainder/div_by_zero until the consumer takes them.
// A zero divisor skips the iterations and returns all-ones / dividend.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   dividend, divisor   operands, captured on accept
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   quotient, remainder registered result
//   div_by_zero         result came from a zero divisor
// -----------------------------------------------------------------------------
module mas_div_seq
  import mas_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_bit;

  mas_div_step #(.WIDTH(WIDTH)) u_step (
    .r_in    (r_q),
    .q_msb   (q_q[WIDTH-1]),
    .divisor (div_q),
    .r_out   (step_r),
    .q_bit   (step_bit)
  );

  // Q starts as the dividend and shifts left each step; the freed LSB takes
  // the new quotient bit, so after WIDTH steps Q holds the full quotient.
  // The result registers are loaded on the final step (or directly on a
  // zero-divisor accept) and stay put through any backpressure.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            state_d = RUN;
            count_d = CNT_LAST;
            q_d     = dividend;
            r_d     = '0;
            div_d   = divisor;
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      RUN: begin
        q_d = {q_q[WIDTH-2:0], step_bit};
        r_d = step_r;
        if (count_q == '0) begin
          state_d = DONE;
          quot_d  = {q_q[WIDTH-2:0], step_bit};
          rem_d   = step_r;
          dbz_d   = 1'b0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags come straight from the state register.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mas_div_seq.sv
// -----------------------------------------------------------------------------
// tb_mas_div_seq
// Bench for mas_div_seq: one WIDTH=8 instance (index 0) and one WIDTH=16
// instance (index 1). Directed vectors from a table, a few hand-written
// handshake/reset sequences, then random pairs scored against plain / and %.
// -----------------------------------------------------------------------------
module tb_mas_div_seq;

  logic        clk;
  logic        rst_n_s     [2];
  logic        in_valid_s  [2];
  logic        out_ready_s [2];
  logic [15:0] dividend_s  [2];
  logic [15:0] divisor_s   [2];
  logic        in_ready_s  [2];
  logic        out_valid_s [2];
  logic [15:0] quotient_s  [2];
  logic [15:0] remainder_s [2];
  logic        dbz_s       [2];

  logic        in_ready8, out_valid8, dbz8;
  logic [7:0]  quot8, rem8;
  logic        in_ready16, out_valid16, dbz16;
  logic [15:0] quot16, rem16;

  int total = 0;
  int bad   = 0;

  mas_div_seq #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n_s[0]),
    .in_valid    (in_valid_s[0]),
    .in_ready    (in_ready8),
    .dividend    (dividend_s[0][7:0]),
    .divisor     (divisor_s[0][7:0]),
    .out_valid   (out_valid8),
    .out_ready   (out_ready_s[0]),
    .quotient    (quot8),
    .remainder   (rem8),
    .div_by_zero (dbz8)
  );

  mas_div_seq #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .rst_n       (rst_n_s[1]),
    .in_valid    (in_valid_s[1]),
    .in_ready    (in_ready16),
    .dividend    (dividend_s[1]),
    .divisor     (divisor_s[1]),
    .out_valid   (out_valid16),
    .out_ready   (out_ready_s[1]),
    .quotient    (quot16),
    .remainder   (rem16),
    .div_by_zero (dbz16)
  );

  assign in_ready_s[0]  = in_ready8;
  assign out_valid_s[0] = out_valid8;
  assign quotient_s[0]  = {8'd0, quot8};
  assign remainder_s[0] = {8'd0, rem8};
  assign dbz_s[0]       = dbz8;
  assign in_ready_s[1]  = in_ready16;
  assign out_valid_s[1] = out_valid16;
  assign quotient_s[1]  = quot16;
  assign remainder_s[1] = rem16;
  assign dbz_s[1]       = dbz16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          stall;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Division as the specification defines it, including the zero-divisor case.
  function automatic void refModel(input int w, input int unsigned a, input int unsigned b,
                                   output logic [15:0] q, output logic [15:0] r, output logic dbz);
    int unsigned ones;
    ones = (32'd1 << w) - 1;
    if (b == 0) begin
      q = 16'(ones); r = 16'(a); dbz = 1'b1;
    end else begin
      q = 16'(a / b); r = 16'(a % b); dbz = 1'b0;
    end
  endfunction

  task automatic checkIdleOutputs(input int idx, input string tag);
    checkOutput({tag, "_in_ready"}, in_ready_s[idx], 1);
    checkOutput({tag, "_out_valid"}, out_valid_s[idx], 0);
    checkOutput({tag, "_quotient"}, quotient_s[idx], 0);
    checkOutput({tag, "_remainder"}, remainder_s[idx], 0);
    checkOutput({tag, "_dbz"}, dbz_s[idx], 0);
  endtask

  // Called at a negedge; returns at a negedge with the instance idle.
  task automatic resetDut(input int idx);
    rst_n_s[idx] = 1'b0;
    @(posedge clk);
    #1;
    rst_n_s[idx]     = 1'b1;
    in_valid_s[idx]  = 1'b0;
    out_ready_s[idx] = 1'b0;
    @(negedge clk);
  endtask

  // One full transaction. Starts and ends at a negedge with the DUT idle.
  // Checks accept, busy in_ready, latency, result, stability under stall
  // and the return to IDLE after the result handshake.
  task automatic applyStimulus(input int idx, input int w, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_q, input logic [15:0] exp_r, input logic exp_dbz,
                               input int pre_idle, input int stall, input bit junk);
    int exp_lat;
    int lat;
    bit seen;
    exp_lat = (b == 16'd0) ? 1 : w + 1;
    lat  = 0;
    seen = 1'b0;
    repeat (pre_idle) @(negedge clk);
    dividend_s[idx] = a;
    divisor_s[idx]  = b;
    in_valid_s[idx] = 1'b1;
    checkOutput("in_ready_idle", in_ready_s[idx], 1);
    @(posedge clk);
    #1;
    in_valid_s[idx] = junk ? 1'($urandom) : 1'b0;
    dividend_s[idx] = 16'($urandom);
    divisor_s[idx]  = 16'($urandom);
    for (int i = 1; i <= exp_lat + 4 && !seen; i++) begin
      @(negedge clk);
      if (out_valid_s[idx]) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        checkOutput("in_ready_busy", in_ready_s[idx], 0);
        if (junk) begin
          in_valid_s[idx] = 1'($urandom);
          dividend_s[idx] = 16'($urandom);
          divisor_s[idx]  = 16'($urandom);
        end
      end
    end
    checkOutput("latency", lat, exp_lat);
    if (!seen) begin
      resetDut(idx);
      return;
    end
    checkOutput("quotient", quotient_s[idx], exp_q);
    checkOutput("remainder", remainder_s[idx], exp_r);
    checkOutput("div_by_zero", dbz_s[idx], exp_dbz);
    checkOutput("in_ready_done", in_ready_s[idx], 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (junk) in_valid_s[idx] = 1'($urandom);
      checkOutput("stall_out_valid", out_valid_s[idx], 1);
      checkOutput("stall_in_ready", in_ready_s[idx], 0);
      checkOutput("stall_quotient", quotient_s[idx], exp_q);
      checkOutput("stall_remainder", remainder_s[idx], exp_r);
      checkOutput("stall_dbz", dbz_s[idx], exp_dbz);
    end
    out_ready_s[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[idx] = 1'b0;
    in_valid_s[idx]  = 1'b0;
    @(negedge clk);
    checkOutput("retire_in_ready", in_ready_s[idx], 1);
    checkOutput("retire_out_valid", out_valid_s[idx], 0);
  endtask

  initial begin
    vec_t        vecs [8];
    logic [15:0] mask, a, b, eq, er;
    logic        ed;

    vecs[0] = '{16'd200, 16'd7,   16'd28,  16'd4,   1'b0, 0};
    vecs[1] = '{16'd5,   16'd0,   16'd255, 16'd5,   1'b1, 0};
    vecs[2] = '{16'd3,   16'd10,  16'd0,   16'd3,   1'b0, 1};
    vecs[3] = '{16'd255, 16'd1,   16'd255, 16'd0,   1'b0, 0};
    vecs[4] = '{16'd255, 16'd255, 16'd1,   16'd0,   1'b0, 2};
    vecs[5] = '{16'd0,   16'd9,   16'd0,   16'd0,   1'b0, 0};
    vecs[6] = '{16'd100, 16'd3,   16'd33,  16'd1,   1'b0, 5};
    vecs[7] = '{16'd0,   16'd0,   16'd255, 16'd0,   1'b1, 3};

    for (int k = 0; k < 2; k++) begin
      rst_n_s[k]     = 1'b0;
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      dividend_s[k]  = 16'd0;
      divisor_s[k]   = 16'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;
    @(negedge clk);
    checkIdleOutputs(0, "reset8");
    checkIdleOutputs(1, "reset16");

    $display("[TB] directed vectors, WIDTH=8");
    foreach (vecs[i])
      applyStimulus(0, 8, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 0, vecs[i].stall, 1'b0);

    // Reset pulse in the middle of 200/7, then a clean 17/4.
    $display("[TB] reset during RUN");
    dividend_s[0] = 16'd200;
    divisor_s[0]  = 16'd7;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    resetDut(0);
    checkIdleOutputs(0, "midrun_reset");
    applyStimulus(0, 8, 16'd17, 16'd4, 16'd4, 16'd1, 1'b0, 0, 0, 1'b0);

    // A new request held during DONE must wait for the result handshake.
    $display("[TB] request held during DONE");
    dividend_s[0] = 16'd9;
    divisor_s[0]  = 16'd2;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    checkOutput("held_first_valid", out_valid_s[0], 1);
    checkOutput("held_first_quotient", quotient_s[0], 4);
    checkOutput("held_first_remainder", remainder_s[0], 1);
    dividend_s[0] = 16'd50;
    divisor_s[0]  = 16'd5;
    in_valid_s[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("held_done_in_ready", in_ready_s[0], 0);
      checkOutput("held_done_out_valid", out_valid_s[0], 1);
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    checkOutput("held_retire_in_ready", in_ready_s[0], 1);
    checkOutput("held_retire_out_valid", out_valid_s[0], 0);
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    checkOutput("held_accepted", in_ready_s[0], 0);
    repeat (7) @(negedge clk);
    @(negedge clk);
    checkOutput("held_second_valid", out_valid_s[0], 1);
    checkOutput("held_second_quotient", quotient_s[0], 10);
    checkOutput("held_second_remainder", remainder_s[0], 0);
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    @(negedge clk);

    // Random pairs with random request gaps, junk inputs and stalls.
    for (int idx = 0; idx < 2; idx++) begin
      int w;
      w    = (idx == 0) ? 8 : 16;
      mask = (idx == 0) ? 16'h00FF : 16'hFFFF;
      $display("[TB] random pairs, WIDTH=%0d", w);
      for (int n = 0; n < 1500; n++) begin
        int sel;
        a   = 16'($urandom) & mask;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      b = 16'd0;
        else if (sel < 4)  b = 16'($urandom_range(1, 7));
        else if (sel == 4) b = mask;
        else               b = 16'($urandom) & mask;
        refModel(w, a, b, eq, er, ed);
        applyStimulus(idx, w, a, b, eq, er, ed,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
